// File: rtl/relay_pkg.sv
// relay_pkg: shared types and helpers for the MOV8 sequencer.
//   reg_code_e   - 3-bit register codes A..Y, used as bit indices on sel/ld
//   mov8_state_e - sequencer FSM states
//   MOV8_OPCODE  - value of instr[7:6] that marks a legal MOV8 byte
//   reg_onehot() - register code to 8-bit one-hot strobe vector
package relay_pkg;

  typedef enum logic [2:0] {
    REG_A  = 3'd0,
    REG_B  = 3'd1,
    REG_C  = 3'd2,
    REG_D  = 3'd3,
    REG_M1 = 3'd4,
    REG_M2 = 3'd5,
    REG_X  = 3'd6,
    REG_Y  = 3'd7
  } reg_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LOAD,
    ST_HOLD,
    ST_DONE,
    ST_ERR
  } mov8_state_e;

  localparam logic [1:0] MOV8_OPCODE = 2'b00;

  function automatic logic [7:0] reg_onehot(input reg_code_e code);
    return 8'b0000_0001 << code;
  endfunction

endpackage

// File: rtl/mov8_sequencer_if.sv
// mov8_sequencer_if: handshake and register-control bus of the MOV8 sequencer.
//   start/instr            - request from the instruction decoder
//   ready/busy/done/err    - sequencer status
//   sel/ld                 - one-hot source select / destination load strobes
// master: decoder side (drives start/instr); slave: the sequencer.
interface mov8_sequencer_if;
  logic       start;
  logic [7:0] instr;
  logic       ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] sel;
  logic [7:0] ld;

  modport master (
    output start, instr,
    input  ready, busy, done, err, sel, ld
  );

  modport slave (
    input  start, instr,
    output ready, busy, done, err, sel, ld
  );
endinterface

// File: rtl/mov8_sequencer_phase_counter.sv
// phase_counter: loadable down-counter timing each sequencer phase.
//   clock, reset - system clock, asynchronous active-high reset
//   i_load       - load i_value this cycle (phase entry)
//   i_value      - phase length minus one
//   o_zero       - count has reached zero; the phase ends on this cycle
// The count saturates at zero so it can never wrap.
module phase_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mov8_sequencer.sv
// mov8_sequencer: sequences one MOV8 register-to-register move on the
// register unit's shared bus.
//   clock, reset - system clock, asynchronous active-high reset
//   bus (slave)  - start/instr request in; ready/busy/done/err status and
//                  one-hot sel/ld strobes out, all registered
// Phases after acceptance: SETTLE (sel), LOAD (sel+ld), HOLD (sel), then a
// one-cycle DONE pulse. A byte with instr[7:6] != 00 yields a one-cycle err
// pulse and no strobes. DONE and ERR accept a new start like IDLE does.
module mov8_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int LOAD_CYCLES   = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic             clock,
  input  logic             reset,
  mov8_sequencer_if.slave  bus
);
  import relay_pkg::*;

  if (SETTLE_CYCLES < 1 || LOAD_CYCLES < 1 || HOLD_CYCLES < 0) begin : g_param_check
    $fatal(1, "mov8_sequencer: illegal phase length parameter");
  end

  localparam int MAX_SL      = (SETTLE_CYCLES > LOAD_CYCLES) ? SETTLE_CYCLES : LOAD_CYCLES;
  localparam int MAX_CYC     = (MAX_SL > HOLD_CYCLES) ? MAX_SL : HOLD_CYCLES;
  localparam int CNT_W       = $clog2(MAX_CYC + 1);
  localparam int HOLD_RELOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

  mov8_state_e      r_state;
  logic [7:0]       r_sel;
  logic [7:0]       r_ld;
  logic [7:0]       r_dst_mask;
  logic             r_busy;
  logic             r_ready;
  logic             r_done;
  logic             r_err;

  reg_code_e        w_src;
  reg_code_e        w_dst;
  logic [7:0]       w_src_mask;
  logic [7:0]       w_dst_mask;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_value;
  logic             w_cnt_zero;

  assign w_src      = reg_code_e'(bus.instr[2:0]);
  assign w_dst      = reg_code_e'(bus.instr[5:3]);
  // src == dst is the "clear register" move: nothing drives the bus while
  // the destination loads, so the register latches zero.
  assign w_src_mask = (w_src == w_dst) ? 8'h00 : reg_onehot(w_src);
  assign w_dst_mask = reg_onehot(w_dst);

  // Counter reload on each phase entry. While accepting, the SETTLE length
  // is preloaded every cycle so it is in place on the acceptance edge.
  // NOTE: every always_comb output gets a default first so no path through
  // the case leaves it unassigned and infers a latch.
  always_comb begin
    w_cnt_load  = 1'b0;
    w_cnt_value = '0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        w_cnt_load  = 1'b1;
        w_cnt_value = CNT_W'(SETTLE_CYCLES - 1);
      end
      ST_SETTLE: begin
        w_cnt_load  = w_cnt_zero;
        w_cnt_value = CNT_W'(LOAD_CYCLES - 1);
      end
      ST_LOAD: begin
        w_cnt_load  = w_cnt_zero;
        w_cnt_value = CNT_W'(HOLD_RELOAD);
      end
      default: ;
    endcase
  end

  phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_cnt_load),
    .i_value (w_cnt_value),
    .o_zero  (w_cnt_zero)
  );

  // Outputs are computed for the next state and registered with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_ld       <= '0;
      r_dst_mask <= '0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          r_state <= ST_IDLE;
          r_sel   <= '0;
          r_ld    <= '0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          if (bus.start) begin
            if (bus.instr[7:6] != MOV8_OPCODE) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state    <= ST_SETTLE;
              r_sel      <= w_src_mask;
              r_dst_mask <= w_dst_mask;
              r_busy     <= 1'b1;
              r_ready    <= 1'b0;
            end
          end
        end
        ST_SETTLE: begin
          if (w_cnt_zero) begin
            r_state <= ST_LOAD;
            r_ld    <= r_dst_mask;
          end
        end
        ST_LOAD: begin
          if (w_cnt_zero) begin
            if (HOLD_CYCLES == 0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_sel   <= '0;
              r_ld    <= '0;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
            end else begin
              r_state <= ST_HOLD;
              r_ld    <= '0;
            end
          end
        end
        ST_HOLD: begin
          if (w_cnt_zero) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sel   = r_sel;
  assign bus.ld    = r_ld;
  assign bus.busy  = r_busy;
  assign bus.ready = r_ready;
  assign bus.done  = r_done;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_mov8_sequencer.sv
// tb_mov8_sequencer: scoreboard bench for mov8_sequencer.
// The stimulus process pushes the hand-computed expected outputs of each
// cycle into a per-DUT queue; a monitor per DUT pops and compares on the
// falling edge. dut0 uses default parameters, dut1 uses SETTLE=2, LOAD=1,
// HOLD=0. Expected words are printed as {sel, ld, busy, ready, done, err}.
module tb_mov8_sequencer;

  typedef struct packed {
    logic [7:0] sel;
    logic [7:0] ld;
    logic       busy;
    logic       ready;
    logic       done;
    logic       err;
  } exp_t;

  typedef struct {
    string name;
    exp_t  e;
  } item_t;

  logic  clock;
  logic  reset;
  int    n_tests;
  int    n_fail;
  item_t q0[$];
  item_t q1[$];

  mov8_sequencer_if bus0();
  mov8_sequencer_if bus1();

  mov8_sequencer dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  mov8_sequencer #(
    .SETTLE_CYCLES (2),
    .LOAD_CYCLES   (1),
    .HOLD_CYCLES   (0)
  ) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [7:0] sel, input logic [7:0] ld,
                              input logic busy, input logic done, input logic err);
    exp_t e;
    e.sel   = sel;
    e.ld    = ld;
    e.busy  = busy;
    e.ready = ~busy;
    e.done  = done;
    e.err   = err;
    return e;
  endfunction

  function automatic exp_t e_idle();
    return mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic exp_t e_done();
    return mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic exp_t e_err();
    return mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic exp_t e_run(input logic [7:0] sel, input logic [7:0] ld);
    return mk(sel, ld, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic exp_t act0();
    return {bus0.sel, bus0.ld, bus0.busy, bus0.ready, bus0.done, bus0.err};
  endfunction

  function automatic exp_t act1();
    return {bus1.sel, bus1.ld, bus1.busy, bus1.ready, bus1.done, bus1.err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle: record what the DUT must show after this rising edge, then
  // drive the inputs it will sample on the next one.
  task automatic cyc(input int dut, input string name, input logic st,
                     input logic [7:0] ins, input exp_t e);
    item_t it;
    @(posedge clock);
    #1;
    it.name = name;
    it.e    = e;
    if (dut == 0) begin
      q0.push_back(it);
      bus0.start = st;
      bus0.instr = ins;
    end else begin
      q1.push_back(it);
      bus1.start = st;
      bus1.instr = ins;
    end
  endtask

  initial begin : mon0
    item_t it;
    forever begin
      @(negedge clock);
      if (q0.size() > 0) begin
        it = q0.pop_front();
        check(it.name, 32'(act0()), 32'(it.e));
      end
    end
  end

  initial begin : mon1
    item_t it;
    forever begin
      @(negedge clock);
      if (q1.size() > 0) begin
        it = q1.pop_front();
        check(it.name, 32'(act1()), 32'(it.e));
      end
    end
  end

  initial begin : stim
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bus0.start = 1'b0;
    bus0.instr = 8'h00;
    bus1.start = 1'b0;
    bus1.instr = 8'h00;

    // Reset state, held and released.
    cyc(0, "rst_a",   1'b0, 8'h00, e_idle());
    cyc(0, "rst_b",   1'b0, 8'h00, e_idle());
    reset = 1'b0;
    cyc(0, "rst_rel", 1'b0, 8'h00, e_idle());

    // 0x0E: dst=B, src=X. instr changes after acceptance must not matter.
    cyc(0, "t1_c0", 1'b1, 8'h0E, e_idle());
    cyc(0, "t1_c1", 1'b0, 8'hFF, e_run(8'h40, 8'h00));
    cyc(0, "t1_c2", 1'b0, 8'h00, e_run(8'h40, 8'h02));
    cyc(0, "t1_c3", 1'b0, 8'h00, e_run(8'h40, 8'h02));
    cyc(0, "t1_c4", 1'b0, 8'h00, e_run(8'h40, 8'h00));
    cyc(0, "t1_c5", 1'b0, 8'h00, e_done());
    cyc(0, "t1_c6", 1'b0, 8'h00, e_idle());

    // 0x1B: dst=D, src=D, clear register: ld only.
    cyc(0, "t2_c0", 1'b1, 8'h1B, e_idle());
    cyc(0, "t2_c1", 1'b0, 8'h00, e_run(8'h00, 8'h00));
    cyc(0, "t2_c2", 1'b0, 8'h00, e_run(8'h00, 8'h08));
    cyc(0, "t2_c3", 1'b0, 8'h00, e_run(8'h00, 8'h08));
    cyc(0, "t2_c4", 1'b0, 8'h00, e_run(8'h00, 8'h00));
    cyc(0, "t2_c5", 1'b0, 8'h00, e_done());
    cyc(0, "t2_c6", 1'b0, 8'h00, e_idle());

    // 0x81: illegal opcode.
    cyc(0, "t3_c0", 1'b1, 8'h81, e_idle());
    cyc(0, "t3_c1", 1'b0, 8'h00, e_err());
    cyc(0, "t3_c2", 1'b0, 8'h00, e_idle());

    // Back-to-back: mid-sequence start ignored, start in done cycle accepted.
    cyc(0, "t4_c0",  1'b1, 8'h0E, e_idle());
    cyc(0, "t4_c1",  1'b0, 8'h00, e_run(8'h40, 8'h00));
    cyc(0, "t4_c2",  1'b1, 8'h81, e_run(8'h40, 8'h02));
    cyc(0, "t4_c3",  1'b0, 8'h00, e_run(8'h40, 8'h02));
    cyc(0, "t4_c4",  1'b0, 8'h00, e_run(8'h40, 8'h00));
    cyc(0, "t4_c5",  1'b1, 8'h38, e_done());
    cyc(0, "t4_b1",  1'b0, 8'h00, e_run(8'h01, 8'h00));
    cyc(0, "t4_b2",  1'b0, 8'h00, e_run(8'h01, 8'h80));
    cyc(0, "t4_b3",  1'b0, 8'h00, e_run(8'h01, 8'h80));
    cyc(0, "t4_b4",  1'b0, 8'h00, e_run(8'h01, 8'h00));
    cyc(0, "t4_b5",  1'b0, 8'h00, e_done());
    cyc(0, "t4_b6",  1'b0, 8'h00, e_idle());

    // Asynchronous reset in cycle 2, then a fresh move.
    cyc(0, "t5_c0", 1'b1, 8'h0E, e_idle());
    cyc(0, "t5_c1", 1'b0, 8'h00, e_run(8'h40, 8'h00));
    @(posedge clock);
    #1;
    check("t5_pre_rst", 32'(act0()), 32'(e_run(8'h40, 8'h02)));
    reset = 1'b1;
    #1;
    check("t5_async_rst", 32'(act0()), 32'(e_idle()));
    begin
      item_t it;
      it.name = "t5_rst_neg";
      it.e    = e_idle();
      q0.push_back(it);
    end
    cyc(0, "t5_rst_hold", 1'b0, 8'h00, e_idle());
    reset = 1'b0;
    cyc(0, "t5_r0", 1'b1, 8'h38, e_idle());
    cyc(0, "t5_r1", 1'b0, 8'h00, e_run(8'h01, 8'h00));
    cyc(0, "t5_r2", 1'b0, 8'h00, e_run(8'h01, 8'h80));
    cyc(0, "t5_r3", 1'b0, 8'h00, e_run(8'h01, 8'h80));
    cyc(0, "t5_r4", 1'b0, 8'h00, e_run(8'h01, 8'h00));
    cyc(0, "t5_r5", 1'b0, 8'h00, e_done());
    cyc(0, "t5_r6", 1'b0, 8'h00, e_idle());

    // dut1 (SETTLE=2, LOAD=1, HOLD=0), 0x3E: dst=Y, src=X.
    cyc(1, "t6_c0", 1'b1, 8'h3E, e_idle());
    cyc(1, "t6_c1", 1'b0, 8'h00, e_run(8'h40, 8'h00));
    cyc(1, "t6_c2", 1'b0, 8'h00, e_run(8'h40, 8'h00));
    cyc(1, "t6_c3", 1'b0, 8'h00, e_run(8'h40, 8'h80));
    cyc(1, "t6_c4", 1'b0, 8'h00, e_done());
    cyc(1, "t6_c5", 1'b0, 8'h00, e_idle());

    repeat (2) @(posedge clock);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
